// File: rtl/adder_serial_if.sv
`default_nettype none
// ============================================================================
// adder_serial_if : request/result bundle for the digit-serial adder
// Rev 1.0
// ============================================================================
interface adder_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/adder_serial.sv
`default_nettype none
// ============================================================================
// adder_serial : multi-cycle add/subtract, DIGIT bits per clock, LSB first
// Rev 1.0
// ============================================================================
module adder_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  adder_serial_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             last;
  logic             accept;

  // Operands shift right one digit per cycle, so the slice adder always
  // reads the low digit; results enter the accumulator from the top.
  always_comb begin
    {dig_cout, dig_sum} = {1'b0, a_q[DIGIT-1:0]}
                        + {1'b0, b_q[DIGIT-1:0]}
                        + {{DIGIT{1'b0}}, carry};
  end

  generate
    if (NDIG > 1) begin : g_shift
      assign a_nxt   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
      assign b_nxt   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
      assign acc_nxt = {dig_sum, acc[WIDTH-1:DIGIT]};
    end else begin : g_whole
      assign a_nxt   = '0;
      assign b_nxt   = '0;
      assign acc_nxt = dig_sum;
    end
  endgenerate

  assign last   = (cnt == CW'(NDIG - 1));
  assign accept = (state == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (last)      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q   <= bus.a;
        b_q   <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.sub ^ bus.cin;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_q   <= a_nxt;
        b_q   <= b_nxt;
        acc   <= acc_nxt;
        carry <= dig_cout;
        cnt   <= cnt + 1'b1;
        if (last) begin
          sum_q  <= acc_nxt;
          cout_q <= dig_cout;
          // carry into the MSB is a^b^s at that bit; XOR with carry out
          ovf_q  <= a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_sum[DIGIT-1] ^ dig_cout;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_serial.sv
`default_nettype none
// ============================================================================
// tb_adder_serial : directed and random checks on DIGIT = 1, 4, 8, 16 builds
// Rev 1.0
// ============================================================================
module tb_adder_serial;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   ncmp  = 0;
  int   nerr  = 0;

  always #5 clk = ~clk;

  adder_serial_if #(.WIDTH(16)) if1 ();
  adder_serial_if #(.WIDTH(16)) if4 ();
  adder_serial_if #(.WIDTH(16)) if8 ();
  adder_serial_if #(.WIDTH(16)) if16 ();

  adder_serial #(.WIDTH(16), .DIGIT(1))  u_d1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  adder_serial #(.WIDTH(16), .DIGIT(4))  u_d4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  adder_serial #(.WIDTH(16), .DIGIT(8))  u_d8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  adder_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  logic        done_v [4];
  logic        busy_v [4];
  logic        cout_v [4];
  logic        ovf_v  [4];
  logic [15:0] sum_v  [4];
  int          dg [4] = '{1, 4, 8, 16};
  int          nd [4] = '{16, 4, 2, 1};

  assign done_v[0] = if1.done;  assign busy_v[0] = if1.busy;
  assign done_v[1] = if4.done;  assign busy_v[1] = if4.busy;
  assign done_v[2] = if8.done;  assign busy_v[2] = if8.busy;
  assign done_v[3] = if16.done; assign busy_v[3] = if16.busy;
  assign sum_v[0]  = if1.sum;   assign cout_v[0] = if1.cout;  assign ovf_v[0] = if1.ovf;
  assign sum_v[1]  = if4.sum;   assign cout_v[1] = if4.cout;  assign ovf_v[1] = if4.ovf;
  assign sum_v[2]  = if8.sum;   assign cout_v[2] = if8.cout;  assign ovf_v[2] = if8.ovf;
  assign sum_v[3]  = if16.sum;  assign cout_v[3] = if16.cout; assign ovf_v[3] = if16.ovf;

  logic [15:0] p_sum  = '0;
  logic        p_cout = 1'b0;
  logic        p_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic s, input logic [15:0] av,
                       input logic [15:0] bv, input logic c);
    if1.start  = st; if1.sub  = s; if1.a  = av; if1.b  = bv; if1.cin  = c;
    if4.start  = st; if4.sub  = s; if4.a  = av; if4.b  = bv; if4.cin  = c;
    if8.start  = st; if8.sub  = s; if8.a  = av; if8.b  = bv; if8.cin  = c;
    if16.start = st; if16.sub = s; if16.a = av; if16.b = bv; if16.cin = c;
  endtask

  // Reference: {ovf, cout, sum} from plain wide arithmetic and sign rules
  function automatic logic [17:0] model(input logic s, input logic [15:0] av,
                                        input logic [15:0] bv, input logic c);
    logic [16:0] t;
    logic [15:0] be;
    logic        ce;
    logic        o;
    be = s ? ~bv : bv;
    ce = s ? ~c : c;
    t  = {1'b0, av} + {1'b0, be} + {16'd0, ce};
    o  = (av[15] == be[15]) && (t[15] != av[15]);
    return {o, t};
  endfunction

  // Called one time unit after a rising edge; all four builds run the op.
  task automatic run_op(input logic s, input logic [15:0] av, input logic [15:0] bv,
                        input logic c, input logic [15:0] es, input logic ec,
                        input logic eo, input bit poke);
    drive(1'b1, s, av, bv, c);
    @(posedge clk); #1;
    drive(1'b0, ~s, 16'($urandom), 16'($urandom), ~c);
    for (int i = 0; i < 4; i++)
      chk($sformatf("d%0d_busy_accept", dg[i]), 32'(busy_v[i]), 32'd1);
    for (int n = 1; n <= 16; n++) begin
      if (poke && n == 2) if4.start = 1'b1;
      @(posedge clk); #1;
      if4.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (n == nd[i]) begin
          chk($sformatf("d%0d_done_n%0d", dg[i], n), 32'(done_v[i]), 32'd1);
          chk($sformatf("d%0d_sum", dg[i]),  32'(sum_v[i]),  32'(es));
          chk($sformatf("d%0d_cout", dg[i]), 32'(cout_v[i]), 32'(ec));
          chk($sformatf("d%0d_ovf", dg[i]),  32'(ovf_v[i]),  32'(eo));
          chk($sformatf("d%0d_busy_end", dg[i]), 32'(busy_v[i]), 32'd0);
        end else if (n < nd[i]) begin
          chk($sformatf("d%0d_done_early_n%0d", dg[i], n), 32'(done_v[i]), 32'd0);
          chk($sformatf("d%0d_busy_n%0d", dg[i], n), 32'(busy_v[i]), 32'd1);
          chk($sformatf("d%0d_sum_held_n%0d", dg[i], n), 32'(sum_v[i]), 32'(p_sum));
        end else begin
          chk($sformatf("d%0d_done_after_n%0d", dg[i], n), 32'(done_v[i]), 32'd0);
          chk($sformatf("d%0d_sum_kept_n%0d", dg[i], n), 32'(sum_v[i]), 32'(es));
        end
      end
    end
    p_sum  = es;
    p_cout = ec;
    p_ovf  = eo;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [17:0] m;
    logic        rs;
    logic        rc;
    logic [15:0] ra;
    logic [15:0] rb;

    // Reset held with live requests on the inputs
    drive(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d%0d_rst_busy", dg[i]), 32'(busy_v[i]), 32'd0);
      chk($sformatf("d%0d_rst_done", dg[i]), 32'(done_v[i]), 32'd0);
      chk($sformatf("d%0d_rst_sum", dg[i]),  32'(sum_v[i]),  32'd0);
      chk($sformatf("d%0d_rst_cout", dg[i]), 32'(cout_v[i]), 32'd0);
      chk($sformatf("d%0d_rst_ovf", dg[i]),  32'(ovf_v[i]),  32'd0);
    end
    drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b1;

    // Directed add / subtract vectors
    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op(1'b1, 16'h0010, 16'h0003, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0);

    // Extra start on the DIGIT=4 build mid-run must be ignored
    run_op(1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b1);

    // Start held high on the DIGIT=4 build: it is re-accepted in the
    // done cycle, so the next done follows NDIG cycles after that.
    if4.start = 1'b1; if4.sub = 1'b0; if4.a = 16'h1234; if4.b = 16'h1111; if4.cin = 1'b0;
    for (int n = 0; n <= 11; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        if4.a = 16'h0F0F;
        if4.b = 16'h00F1;
      end
      if (n == 5) if4.start = 1'b0;
      chk($sformatf("b2b_done_n%0d", n), 32'(done_v[1]), 32'((n == 4) || (n == 9)));
      chk($sformatf("b2b_busy_n%0d", n), 32'(busy_v[1]), 32'((n < 4) || (n >= 5 && n < 9)));
      if (n == 4) chk("b2b_sum_first",  32'(sum_v[1]), 32'h2345);
      if (n == 9) chk("b2b_sum_second", 32'(sum_v[1]), 32'h1000);
    end

    // Asynchronous reset in the middle of a run
    drive(1'b1, 1'b0, 16'hAAAA, 16'h5555, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d%0d_abort_busy", dg[i]), 32'(busy_v[i]), 32'd0);
      chk($sformatf("d%0d_abort_done", dg[i]), 32'(done_v[i]), 32'd0);
      chk($sformatf("d%0d_abort_sum", dg[i]),  32'(sum_v[i]),  32'd0);
      chk($sformatf("d%0d_abort_cout", dg[i]), 32'(cout_v[i]), 32'd0);
      chk($sformatf("d%0d_abort_ovf", dg[i]),  32'(ovf_v[i]),  32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("d%0d_post_abort_done_n%0d", dg[i], n), 32'(done_v[i]), 32'd0);
        chk($sformatf("d%0d_post_abort_busy_n%0d", dg[i], n), 32'(busy_v[i]), 32'd0);
      end
    end
    p_sum  = '0;
    p_cout = 1'b0;
    p_ovf  = 1'b0;

    // Random operands against the reference model
    for (int k = 0; k < 8; k++) begin
      rs = 1'($urandom);
      rc = 1'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      m  = model(rs, ra, rb, rc);
      run_op(rs, ra, rb, rc, m[15:0], m[16], m[17], 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
`default_nettype wire
